// File: rtl/sweeper_pkg.sv
// Shared types and helpers for the exhaustive pattern sweeper.
// Holds the FSM state enum, order-mode constants, pattern mapping and default MISR polynomial.
package sweeper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        EMIT,
        DONE
    } state_t;

    localparam int GRAY_OFF = 0;
    localparam int GRAY_ON  = 1;

    localparam logic [15:0] DEFAULT_SIG_POLY = 16'h1021;

    // Mapping works on a wide word; callers cast down to their pattern width.
    localparam int MAP_W = 32;

    function automatic logic [MAP_W-1:0] map_pattern(
        input logic [MAP_W-1:0] idx,
        input logic             gray
    );
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register folding one response word per enable.
// Ports: clk, rst (async, active-high), clear, enable, data[OUT_WIDTH], sig[SIG_WIDTH].
module sweep_misr
    import sweeper_pkg::*;
#(
    parameter int                   SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY  = SIG_WIDTH'(DEFAULT_SIG_POLY),
    parameter int                   OUT_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [OUT_WIDTH-1:0] data,
    output logic [SIG_WIDTH-1:0] sig
);

    logic [SIG_WIDTH-1:0] feedback;
    logic [SIG_WIDTH-1:0] sig_next;

    always_comb begin
        feedback = sig[SIG_WIDTH-1] ? SIG_POLY : '0;
        sig_next = {sig[SIG_WIDTH-2:0], 1'b0} ^ feedback ^ SIG_WIDTH'(data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/exhaustive_pattern_sweeper.sv
// Drives all 2^N_WIDTH patterns (binary or Gray order) to a DUT, captures each response,
// streams pattern/response records over valid/ready and folds responses into a MISR.
// Ports: CK, reset (async, active-high), start, abort, pattern, dut_resp, rec_valid,
// rec_ready, rec_pattern, rec_resp, busy, done, signature, pattern_count.
module exhaustive_pattern_sweeper
    import sweeper_pkg::*;
#(
    parameter int                   N_WIDTH       = 6,
    parameter int                   OUT_WIDTH     = 1,
    parameter int                   SETTLE_CYCLES = 1,
    parameter int                   GRAY_MODE     = GRAY_OFF,
    parameter int                   SIG_WIDTH     = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY      = SIG_WIDTH'(DEFAULT_SIG_POLY)
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_WIDTH-1:0]   pattern,
    input  logic [OUT_WIDTH-1:0] dut_resp,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [N_WIDTH-1:0]   rec_pattern,
    output logic [OUT_WIDTH-1:0] rec_resp,
    output logic                 busy,
    output logic                 done,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [N_WIDTH:0]     pattern_count
);

    localparam int IW = N_WIDTH + 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // idx carries one extra bit so the last index never wraps to 0.
    localparam logic [IW-1:0] LAST_IDX    = IW'((1 << N_WIDTH) - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic          GRAY_SEL    = (GRAY_MODE == GRAY_ON);

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_inc;
    logic [CW-1:0] settle_cnt;
    logic          start_go;
    logic          capture_go;
    logic          accept;
    logic          advance;

    assign idx_inc = idx + IW'(1);

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_go   = 1'b0;
        capture_go = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    start_go = 1'b1;
                end
            end
            SETTLE: begin
                // Response is sampled on the edge that ends the last settle cycle.
                if (settle_cnt == SETTLE_LAST) begin
                    state_d    = CAPTURE;
                    capture_go = 1'b1;
                end
            end
            CAPTURE: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (rec_ready) begin
                    accept = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort overrides every other event, including a completing handshake.
        if (abort) begin
            state_d    = IDLE;
            start_go   = 1'b0;
            capture_go = 1'b0;
            accept     = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            settle_cnt    <= '0;
            pattern       <= '0;
            rec_pattern   <= '0;
            rec_resp      <= '0;
            rec_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pattern_count <= '0;
        end else begin
            settle_cnt <= (state_q == SETTLE && state_d == SETTLE)
                          ? settle_cnt + CW'(1) : '0;
            if (start_go) begin
                idx           <= '0;
                pattern_count <= '0;
                pattern       <= N_WIDTH'(map_pattern('0, GRAY_SEL));
            end
            if (capture_go) begin
                rec_resp    <= dut_resp;
                rec_pattern <= pattern;
            end
            if (accept) begin
                pattern_count <= pattern_count + IW'(1);
            end
            if (advance) begin
                idx     <= idx_inc;
                pattern <= N_WIDTH'(map_pattern(MAP_W'(idx_inc), GRAY_SEL));
            end
            rec_valid <= (state_d == EMIT);
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
        end
    end

    sweep_misr #(
        .SIG_WIDTH (SIG_WIDTH),
        .SIG_POLY  (SIG_POLY),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_misr (
        .clk    (CK),
        .rst    (reset),
        .clear  (start_go),
        .enable (capture_go),
        .data   (dut_resp),
        .sig    (signature)
    );

endmodule

// File: tb/tb_exhaustive_pattern_sweeper.sv
// Scoreboard bench for exhaustive_pattern_sweeper across binary, Gray and long-settle builds.
// Covers reset, full sweeps, backpressure, abort and mid-sweep reset.
module tb_exhaustive_pattern_sweeper;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic reset = 1'b1;
    logic start_a = 1'b0, start_g = 1'b0, start_p = 1'b0;
    logic abort_a = 1'b0;
    logic abort_n = 1'b0;
    logic ready = 1'b1;
    logic zero_resp = 1'b1;

    // Instance A: defaults, N=6, binary, settle 1
    logic [5:0]  pat_a, rp_a;
    logic [0:0]  rr_a, resp_a;
    logic        valid_a, busy_a, done_a;
    logic [15:0] sig_a;
    logic [6:0]  cnt_a;
    assign resp_a = zero_resp ? 1'b0 : ^pat_a;

    exhaustive_pattern_sweeper u_a (
        .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
        .pattern(pat_a), .dut_resp(resp_a), .rec_valid(valid_a),
        .rec_ready(ready), .rec_pattern(rp_a), .rec_resp(rr_a),
        .busy(busy_a), .done(done_a), .signature(sig_a),
        .pattern_count(cnt_a)
    );

    // Instance G: N=3, Gray order
    logic [2:0]  pat_g, rp_g;
    logic [0:0]  rr_g, resp_g;
    logic        valid_g, busy_g, done_g;
    logic [15:0] sig_g;
    logic [3:0]  cnt_g;
    assign resp_g = ^pat_g;

    exhaustive_pattern_sweeper #(.N_WIDTH(3), .GRAY_MODE(1)) u_g (
        .CK(CK), .reset(reset), .start(start_g), .abort(abort_n),
        .pattern(pat_g), .dut_resp(resp_g), .rec_valid(valid_g),
        .rec_ready(ready), .rec_pattern(rp_g), .rec_resp(rr_g),
        .busy(busy_g), .done(done_g), .signature(sig_g),
        .pattern_count(cnt_g)
    );

    // Instance P: N=4, settle 3, parity response
    logic [3:0]  pat_p, rp_p;
    logic [0:0]  rr_p, resp_p;
    logic        valid_p, busy_p, done_p;
    logic [15:0] sig_p;
    logic [4:0]  cnt_p;
    assign resp_p = ^pat_p;

    exhaustive_pattern_sweeper #(.N_WIDTH(4), .SETTLE_CYCLES(3)) u_p (
        .CK(CK), .reset(reset), .start(start_p), .abort(abort_n),
        .pattern(pat_p), .dut_resp(resp_p), .rec_valid(valid_p),
        .rec_ready(ready), .rec_pattern(rp_p), .rec_resp(rr_p),
        .busy(busy_p), .done(done_p), .signature(sig_p),
        .pattern_count(cnt_p)
    );

    int          sel = 0;
    logic [5:0]  obs_stim, obs_rpat;
    logic        obs_resp, obs_valid, obs_busy, obs_done;
    logic [15:0] obs_sig;
    logic [6:0]  obs_cnt;

    always_comb begin
        obs_stim  = pat_a;
        obs_rpat  = rp_a;
        obs_resp  = rr_a[0];
        obs_valid = valid_a;
        obs_busy  = busy_a;
        obs_done  = done_a;
        obs_sig   = sig_a;
        obs_cnt   = cnt_a;
        case (sel)
            1: begin
                obs_stim  = 6'(pat_g);
                obs_rpat  = 6'(rp_g);
                obs_resp  = rr_g[0];
                obs_valid = valid_g;
                obs_busy  = busy_g;
                obs_done  = done_g;
                obs_sig   = sig_g;
                obs_cnt   = 7'(cnt_g);
            end
            2: begin
                obs_stim  = 6'(pat_p);
                obs_rpat  = 6'(rp_p);
                obs_resp  = rr_p[0];
                obs_valid = valid_p;
                obs_busy  = busy_p;
                obs_done  = done_p;
                obs_sig   = sig_p;
                obs_cnt   = 7'(cnt_p);
            end
            default: ;
        endcase
    end

    int n_assert = 0;
    int n_fail   = 0;
    logic [6:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] misr_ref(input logic [15:0] s,
                                             input logic r);
        logic [15:0] n;
        n = {s[14:0], 1'b0};
        if (s[15]) n = n ^ 16'h1021;
        n[0] = n[0] ^ r;
        return n;
    endfunction

    task automatic pulse_start(input int s);
        @(negedge CK);
        case (s)
            1: start_g = 1'b1;
            2: start_p = 1'b1;
            default: start_a = 1'b1;
        endcase
        @(posedge CK);
        #1;
        start_a = 1'b0;
        start_g = 1'b0;
        start_p = 1'b0;
    endtask

    task automatic sweep(input int s, input int npat, input bit gray,
                         input int exp_cyc, input int stall_at);
        logic [15:0] msig = '0;
        logic [5:0]  p;
        logic [5:0]  prev = '0;
        logic        r;
        logic [6:0]  e;
        int          k = 0;
        bit          seen = 0;
        bit          stalled = 0;
        bit          first = 1;
        exp_q.delete();
        for (int i = 0; i < npat; i++) begin
            p = gray ? 6'(i ^ (i >> 1)) : 6'(i);
            r = zero_resp ? 1'b0 : ^p;
            exp_q.push_back({r, p});
            msig = misr_ref(msig, r);
        end
        sel = s;
        pulse_start(s);
        check("first_pattern", 32'(obs_stim), 0);
        check("busy_on_start", 32'(obs_busy), 1);
        while (!seen && k < exp_cyc + 50) begin
            @(negedge CK);
            if (obs_done) begin
                seen = 1;
                check("done_cycle", k, exp_cyc);
            end else if (obs_valid) begin
                if (!stalled && 32'(obs_rpat) == stall_at) begin
                    stalled = 1;
                    ready = 1'b0;
                    repeat (10) begin
                        @(posedge CK);
                        k++;
                        @(negedge CK);
                        check("stall_valid", 32'(obs_valid), 1);
                        check("stall_rec_pattern", 32'(obs_rpat), stall_at);
                        check("stall_pattern", 32'(obs_stim), stall_at);
                        check("stall_count", 32'(obs_cnt), stall_at);
                    end
                    ready = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    check("extra_record", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rec_pattern", 32'(obs_rpat), 32'(e[5:0]));
                    check("rec_resp", 32'(obs_resp), 32'(e[6]));
                    if (gray && !first)
                        check("gray_step", $countones(prev ^ obs_rpat), 1);
                    prev  = obs_rpat;
                    first = 0;
                end
            end
            @(posedge CK);
            k++;
        end
        if (!seen) check("done_timeout", 0, 1);
        check("records_left", exp_q.size(), 0);
        check("signature", 32'(obs_sig), 32'(msig));
        check("pattern_count", 32'(obs_cnt), npat);
        @(negedge CK);
        check("idle_after_done", 32'(obs_busy), 0);
        check("done_one_cycle", 32'(obs_done), 0);
    endtask

    initial begin : main
        logic [15:0] msig;
        int          k;
        bit          found;
        bit          done_seen;

        repeat (3) @(posedge CK);
        @(negedge CK);
        check("rst_pattern", 32'(pat_a), 0);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_sig", 32'(sig_a), 0);
        check("rst_count", 32'(cnt_a), 0);
        check("rst_rec_pattern", 32'(rp_a), 0);
        reset = 1'b0;

        zero_resp = 1'b1;
        sweep(0, 64, 1'b0, 192, -1);

        zero_resp = 1'b0;
        sweep(0, 64, 1'b0, 202, 5);
        sweep(1, 8, 1'b1, 24, -1);
        sweep(2, 16, 1'b0, 80, -1);

        // Abort in SETTLE of pattern 20
        sel = 0;
        msig = '0;
        for (int i = 0; i < 20; i++) msig = misr_ref(msig, ^6'(i));
        pulse_start(0);
        k = 0;
        found = 0;
        while (!found && k < 300) begin
            @(negedge CK);
            if (pat_a == 6'd20 && !valid_a) found = 1;
            else begin
                @(posedge CK);
                k++;
            end
        end
        if (!found) check("abort_wait_timeout", 0, 1);
        abort_a = 1'b1;
        @(posedge CK);
        #1 abort_a = 1'b0;
        check("abort_busy", 32'(busy_a), 0);
        check("abort_valid", 32'(valid_a), 0);
        check("abort_count", 32'(cnt_a), 20);
        check("abort_sig", 32'(sig_a), 32'(msig));
        done_seen = 0;
        repeat (8) begin
            @(negedge CK);
            if (done_a) done_seen = 1;
        end
        check("abort_no_done", 32'(done_seen), 0);
        check("abort_stay_idle", 32'(busy_a), 0);

        pulse_start(0);
        check("restart_pattern", 32'(pat_a), 0);
        check("restart_sig", 32'(sig_a), 0);
        check("restart_count", 32'(cnt_a), 0);
        check("restart_busy", 32'(busy_a), 1);

        // Reset during EMIT of pattern 40
        k = 0;
        found = 0;
        while (!found && k < 300) begin
            @(negedge CK);
            if (valid_a && rp_a == 6'd40) found = 1;
            else begin
                @(posedge CK);
                k++;
            end
        end
        if (!found) check("reset_wait_timeout", 0, 1);
        check("emit_pattern_40", 32'(pat_a), 40);
        reset = 1'b1;
        #1;
        check("async_rst_pattern", 32'(pat_a), 0);
        check("async_rst_valid", 32'(valid_a), 0);
        check("async_rst_rec_pattern", 32'(rp_a), 0);
        check("async_rst_rec_resp", 32'(rr_a), 0);
        check("async_rst_busy", 32'(busy_a), 0);
        check("async_rst_sig", 32'(sig_a), 0);
        check("async_rst_count", 32'(cnt_a), 0);
        start_a = 1'b1;
        repeat (3) @(posedge CK);
        @(negedge CK);
        check("start_in_reset", 32'(busy_a), 0);
        start_a = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        check("idle_after_reset", 32'(busy_a), 0);
        check("pattern_after_reset", 32'(pat_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
